bfu_dif_pipe: RTL and testbench
===============================

Name: bfu_dif_pipe

Overview:
- Pipelined radix-2 decimation-in-frequency butterfly. It sits directly downstream of the twiddle generator and consumes its 16-bit signed cos / minus-sine outputs.
- Computes x = a + b and y = (a − b)·W on complex 16-bit samples.
- Optional per-sample divide-by-2 for stage scaling.
- Valid/ready streaming with backpressure, so the FFT stage controller can stall it.

Parameters:
- DW, 16, sample component width (signed two's complement).
- TW_FRAC, 14, twiddle fractional bits; +1.0 = 2^TW_FRAC = 16384, so twiddle is Q2.14.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input this cycle.
- scale  in  1  1 = divide both outputs by 2; sampled with the input.
- a_re, a_im  in  DW each  upper input leg.
- b_re, b_im  in  DW each  lower input leg.
- tw_re, tw_im  in  16 each  twiddle W = tw_re + j·tw_im, as produced by the twiddle generator.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- x_re, x_im  out  DW each  sum leg.
- y_re, y_im  out  DW each  difference leg times twiddle.

Behaviour:
- Reset (async assert, synchronous release): all valid bits, data registers and outputs are 0; in_ready = 1 after reset.
- Stage enable en = ~out_valid | out_ready. in_ready = en.
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Pipeline of 3 register stages, all advancing together on en:
  - Each stage holds a valid bit; bubbles are not collapsed.
  - Latency is exactly 3 enabled cycles from input transfer to out_valid.
  - When en = 0, every stage holds its value, including data, valid and scale.
- S1:
  - xs = a + b and d = a − b, computed at DW+1 bits (17b), no overflow.
  - Twiddle and scale are registered alongside.
- S2, four signed products at 33b:
  - pr = d_re·tw_re
  - pi = d_im·tw_im
  - qr = d_re·tw_im
  - qi = d_im·tw_re
  - xs is delayed alongside.
- S3 (output registers):
  - yr = pr − pi and yi = qr + qi, computed at 34b.
  - Shift amount sh = TW_FRAC + scale.
  - Rounding is round-half-up: add 2^(sh−1), then arithmetic shift right by sh.
  - x path uses shift s = scale: if s = 1, add 1 then arithmetic shift right by 1; if s = 0, pass unchanged.
  - Saturation to DW bits on all four results: values above 32767 → 32767, values below −32768 → −32768.
- Output data is stable while out_valid = 1 and out_ready = 0.
- Throughput: one sample per cycle while out_ready = 1.
- In-flight data is discarded on reset assertion at any time, including mid-stream.
- in_valid = 0 inserts a bubble; the bubble propagates with out_valid = 0 for that slot.

Test Plan:
- Reset, then a = (1000, 200), b = (600, −100), W = (16384, 0), scale = 0, out_ready = 1:
  - 3 cycles later out_valid = 1 for exactly 1 cycle.
  - x = (1600, 100), y = (400, 300).
- Same a, b with W = (0, −16384) (−j):
  - y = (300, −400), x = (1600, 100).
  - Repeat with scale = 1 → x = (800, 50), y = (150, −200).
- Saturation:
  - a = b = (32767, −32768), scale = 0 → x = (32767, −32768).
  - Same input with scale = 1 → x = (32767, −32768) after rounding: 65534→32767 and −65536→−32768.
  - a = (32767, 0), b = (−32768, 0), W = (16384, 0) → y_re = 32767 (saturated from 65535).
- Rounding, with b = 0, W = (8192, 0), scale = 0:
  - a_re = 3 → y_re = 2.
  - a_re = −3 → y_re = −1.
  - a_re = 1 → y_re = 1.
- Backpressure:
  - Stream 5 back-to-back samples.
  - Drop out_ready for 2 cycles while out_valid = 1.
  - in_ready falls in the same cycle; output data holds.
  - All 5 results emerge in order, none lost or duplicated.
- Assert rst mid-stream with 3 samples in flight:
  - out_valid = 0 immediately; all outputs 0.
  - After release, a new sample produces a correct result 3 cycles later, with no stale output.

Source files
------------

// File: rtl/bfu_dif_pipe.sv
// Pipelined radix-2 DIF butterfly: x = a + b, y = (a - b) * W, with optional
// divide-by-2, round-half-up and saturation, behind a 3-stage valid/ready pipe.
module bfu_dif_pipe #(
  parameter int DW      = 16,
  parameter int TW_FRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 scale,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [15:0]   tw_re,
  input  logic signed [15:0]   tw_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x_re,
  output logic signed [DW-1:0] x_im,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im
);

  localparam int SW = DW + 1;
  localparam int PW = SW + 16;
  localparam int YW = PW + 1;

  localparam logic signed [YW-1:0] X_ONE  = {{(YW-1){1'b0}}, 1'b1};
  localparam logic signed [YW-1:0] RND_Y0 = X_ONE << (TW_FRAC - 1);
  localparam logic signed [YW-1:0] RND_Y1 = X_ONE << TW_FRAC;

  // Clamp a wide signed value into DW bits; in range when all bits above the DW sign bit agree.
  function automatic logic signed [DW-1:0] sat(input logic signed [YW-1:0] v);
    logic [YW-DW:0] top;
    top = v[YW-1:DW-1];
    if ((&top) || !(|top)) begin
      sat = v[DW-1:0];
    end else if (v[YW-1]) begin
      sat = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat = {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  logic en_s;

  logic                 v1_r, sc1_r;
  logic signed [SW-1:0] xs_re_r, xs_im_r, d_re_r, d_im_r;
  logic signed [15:0]   tw_re_r, tw_im_r;

  logic                 v2_r, sc2_r;
  logic signed [SW-1:0] xs2_re_r, xs2_im_r;
  logic signed [PW-1:0] pr_r, pi_r, qr_r, qi_r;

  logic signed [YW-1:0] yr_s, yi_s, xr_ext_s, xi_ext_s;
  logic signed [YW-1:0] yr_rnd_s, yi_rnd_s, xr_rnd_s, xi_rnd_s;

  assign en_s     = ~out_valid | out_ready;
  assign in_ready = en_s;

  // Final combine, scale-dependent rounding shift for both legs.
  always_comb begin
    yr_s     = YW'(pr_r) - YW'(pi_r);
    yi_s     = YW'(qr_r) + YW'(qi_r);
    xr_ext_s = YW'(xs2_re_r);
    xi_ext_s = YW'(xs2_im_r);
    if (sc2_r) begin
      yr_rnd_s = (yr_s + RND_Y1) >>> (TW_FRAC + 1);
      yi_rnd_s = (yi_s + RND_Y1) >>> (TW_FRAC + 1);
      xr_rnd_s = (xr_ext_s + X_ONE) >>> 1;
      xi_rnd_s = (xi_ext_s + X_ONE) >>> 1;
    end else begin
      yr_rnd_s = (yr_s + RND_Y0) >>> TW_FRAC;
      yi_rnd_s = (yi_s + RND_Y0) >>> TW_FRAC;
      xr_rnd_s = xr_ext_s;
      xi_rnd_s = xi_ext_s;
    end
  end

  // Three lock-step stages; a stall freezes data, valid and scale everywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r      <= 1'b0;
      sc1_r     <= 1'b0;
      xs_re_r   <= '0;
      xs_im_r   <= '0;
      d_re_r    <= '0;
      d_im_r    <= '0;
      tw_re_r   <= '0;
      tw_im_r   <= '0;
      v2_r      <= 1'b0;
      sc2_r     <= 1'b0;
      xs2_re_r  <= '0;
      xs2_im_r  <= '0;
      pr_r      <= '0;
      pi_r      <= '0;
      qr_r      <= '0;
      qi_r      <= '0;
      out_valid <= 1'b0;
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
    end else if (en_s) begin
      v1_r      <= in_valid;
      sc1_r     <= scale;
      xs_re_r   <= SW'(a_re) + SW'(b_re);
      xs_im_r   <= SW'(a_im) + SW'(b_im);
      d_re_r    <= SW'(a_re) - SW'(b_re);
      d_im_r    <= SW'(a_im) - SW'(b_im);
      tw_re_r   <= tw_re;
      tw_im_r   <= tw_im;

      v2_r      <= v1_r;
      sc2_r     <= sc1_r;
      xs2_re_r  <= xs_re_r;
      xs2_im_r  <= xs_im_r;
      pr_r      <= PW'(d_re_r) * PW'(tw_re_r);
      pi_r      <= PW'(d_im_r) * PW'(tw_im_r);
      qr_r      <= PW'(d_re_r) * PW'(tw_im_r);
      qi_r      <= PW'(d_im_r) * PW'(tw_re_r);

      out_valid <= v2_r;
      x_re      <= sat(xr_rnd_s);
      x_im      <= sat(xi_rnd_s);
      y_re      <= sat(yr_rnd_s);
      y_im      <= sat(yi_rnd_s);
    end
  end

endmodule

// File: tb/tb_bfu_dif_pipe.sv
// Self-checking bench for bfu_dif_pipe: directed vector table, backpressure and
// reset sequences, and a randomized stream scored against an arithmetic model.
module tb_bfu_dif_pipe;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, scale, out_valid, out_ready;
  logic signed [15:0] a_re, a_im, b_re, b_im, tw_re, tw_im;
  logic signed [15:0] x_re, x_im, y_re, y_im;

  always #5 clk = ~clk;

  bfu_dif_pipe #(.DW(16), .TW_FRAC(14)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .scale(scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im)
  );

  typedef struct { longint xr, xi, yr, yi; } res_t;
  typedef struct {
    longint ar, ai, br, bi, wr, wi;
    bit     sc;
    longint xr, xi, yr, yi;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  bit   sb_on = 1'b0;
  res_t sbq[$];
  vec_t tbl[10];

  function automatic longint floor_div(longint n, longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clip(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // x = (a+b)/k, y = (a-b)*W/(16384*k), both rounded half-up, then clipped.
  function automatic res_t model(longint ar, ai, br, bi, wr, wi, bit sc);
    res_t   r;
    longint k, den, dr, di;
    k   = sc ? 2 : 1;
    den = 16384 * k;
    dr  = ar - br;
    di  = ai - bi;
    r.xr = clip(floor_div(ar + br + k / 2, k));
    r.xi = clip(floor_div(ai + bi + k / 2, k));
    r.yr = clip(floor_div(dr * wr - di * wi + den / 2, den));
    r.yi = clip(floor_div(dr * wi + di * wr + den / 2, den));
    return r;
  endfunction

  function automatic vec_t mk(longint ar, ai, br, bi, wr, wi, bit sc,
                              longint xr, xi, yr, yi);
    vec_t v;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.wr = wr; v.wi = wi; v.sc = sc;
    v.xr = xr; v.xi = xi; v.yr = yr; v.yi = yi;
    return v;
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_sample(vec_t v);
    a_re = 16'(v.ar); a_im = 16'(v.ai);
    b_re = 16'(v.br); b_im = 16'(v.bi);
    tw_re = 16'(v.wr); tw_im = 16'(v.wi);
    scale = v.sc;
  endtask

  task automatic rand_sample();
    a_re = 16'($urandom); a_im = 16'($urandom);
    b_re = 16'($urandom); b_im = 16'($urandom);
    tw_re = 16'($urandom); tw_im = 16'($urandom);
    scale = 1'($urandom);
  endtask

  // Scoreboard: inputs and outputs are stable at the falling edge and transfer on the next rising edge.
  always @(negedge clk) begin
    if (!rst && sb_on) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          res_t e;
          e = sbq.pop_front();
          check("sb_x_re", x_re, e.xr);
          check("sb_x_im", x_im, e.xi);
          check("sb_y_re", y_re, e.yr);
          check("sb_y_im", y_im, e.yi);
        end
      end
      if (in_valid && in_ready)
        sbq.push_back(model(a_re, a_im, b_re, b_im, tw_re, tw_im, scale));
    end
  end

  task automatic apply_one(vec_t v, string tag);
    int n;
    @(posedge clk); #1;
    set_sample(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    check({tag, "_latency"}, n, 3);
    check({tag, "_x_re"}, x_re, v.xr);
    check({tag, "_x_im"}, x_im, v.xi);
    check({tag, "_y_re"}, y_re, v.yr);
    check({tag, "_y_im"}, y_im, v.yi);
    @(posedge clk); #1;
    check({tag, "_single_valid"}, out_valid, 0);
  endtask

  initial begin
    int idx, out0;
    bit fresh;
    logic signed [15:0] hx, hy;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; scale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw_re = '0; tw_im = '0;

    tbl[0] = mk(1000, 200, 600, -100, 16384, 0, 0, 1600, 100, 400, 300);
    tbl[1] = mk(1000, 200, 600, -100, 0, -16384, 0, 1600, 100, 300, -400);
    tbl[2] = mk(1000, 200, 600, -100, 0, -16384, 1, 800, 50, 150, -200);
    tbl[3] = mk(32767, -32768, 32767, -32768, 16384, 0, 0, 32767, -32768, 0, 0);
    tbl[4] = mk(32767, -32768, 32767, -32768, 16384, 0, 1, 32767, -32768, 0, 0);
    tbl[5] = mk(32767, 0, -32768, 0, 16384, 0, 0, -1, 0, 32767, 0);
    tbl[6] = mk(-32768, 0, 32767, 0, 16384, 0, 0, -1, 0, -32768, 0);
    tbl[7] = mk(3, 0, 0, 0, 8192, 0, 0, 3, 0, 2, 0);
    tbl[8] = mk(-3, 0, 0, 0, 8192, 0, 0, -3, 0, -1, 0);
    tbl[9] = mk(1, 0, 0, 0, 8192, 0, 0, 1, 0, 1, 0);

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_x_re", x_re, 0);
    check("rst_y_im", y_im, 0);
    @(negedge clk);
    rst = 1'b0;
    sb_on = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) apply_one(tbl[i], $sformatf("vec%0d", i));

    // Five back-to-back samples with a two-cycle output stall while the first result is presented.
    idx = 0; fresh = 1'b1; out0 = n_out;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      out_ready = !(k == 3 || k == 4);
      #1;
      if (k == 3) begin
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready_low", in_ready, 0);
        hx = x_re; hy = y_re;
      end
      if (k == 4) begin
        check("bp_in_ready_low2", in_ready, 0);
        check("bp_hold_x_re", x_re, hx);
        check("bp_hold_y_re", y_re, hy);
      end
      if (idx < 5 && fresh) rand_sample();
      fresh = 1'b0;
      in_valid = (idx < 5);
      if (in_valid && in_ready) begin
        idx++;
        fresh = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("bp_count", n_out - out0, 5);
    check("bp_sb_empty", sbq.size(), 0);

    // Reset with three samples in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_sample();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    sbq.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_x_re", x_re, 0);
    check("midrst_x_im", x_im, 0);
    check("midrst_y_re", y_re, 0);
    check("midrst_y_im", y_im, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply_one(tbl[2], "after_rst");

    // Randomized traffic with random bubbles and stalls.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      rand_sample();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain_sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
